// File: rtl/dispatch_queue_pkg.sv
// Shared widths, instruction-type encodings and operand helpers for the dispatch queue.
package dispatch_queue_pkg;

    localparam int REGBW = 5;
    localparam int ROBBW = 4;

    typedef enum logic [2:0] {
        TYPE_INVALID = 3'd0,
        TYPE_R       = 3'd1,
        TYPE_I       = 3'd2,
        TYPE_LOAD    = 3'd3,
        TYPE_STORE   = 3'd4,
        TYPE_B       = 3'd5,
        TYPE_U       = 3'd6,
        TYPE_J       = 3'd7
    } inst_type_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0]      v;
        logic [ROBBW-1:0] q;
    } operand_t;

    function automatic logic is_lsb_type(input inst_type_e t);
        return (t == TYPE_LOAD) || (t == TYPE_STORE);
    endfunction

    // ROB id 0 means "no dependency", so it must never match a CDB broadcast.
    function automatic operand_t resolve_operand(
        input logic [REGBW-1:0] rs,
        input logic [31:0]      v_rf,
        input logic [ROBBW-1:0] q_rf,
        input logic             cdb_flag,
        input logic [ROBBW-1:0] cdb_rob_id,
        input logic [31:0]      cdb_value
    );
        operand_t op;
        if (rs == '0) begin
            op.v = '0;
            op.q = '0;
        end else if (cdb_flag && (q_rf == cdb_rob_id) && (q_rf != '0)) begin
            op.v = cdb_value;
            op.q = '0;
        end else begin
            op.v = v_rf;
            op.q = q_rf;
        end
        return op;
    endfunction

endpackage

// File: rtl/dispatch_queue_decoder.sv
// Combinational RV32I format decoder; register fields not used by a format are returned as 0.
module dispatch_queue_decoder
    import dispatch_queue_pkg::*;
(
    input  logic [31:0]      inst,
    output logic [REGBW-1:0] rd,
    output logic [REGBW-1:0] rs1,
    output logic [REGBW-1:0] rs2,
    output logic [31:0]      imm,
    output logic [5:0]       code,
    output inst_type_e       itype
);

    logic [6:0] opc;
    logic [2:0] funct3;
    logic       alt;

    assign opc    = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        itype = TYPE_INVALID;
        case (opc)
            OPC_LUI, OPC_AUIPC:  itype = TYPE_U;
            OPC_JAL:             itype = TYPE_J;
            OPC_JALR, OPC_OPIMM: itype = TYPE_I;
            OPC_BRANCH:          itype = TYPE_B;
            OPC_LOAD:            itype = TYPE_LOAD;
            OPC_STORE:           itype = TYPE_STORE;
            OPC_OP:              itype = TYPE_R;
            default:             itype = TYPE_INVALID;
        endcase
    end

    always_comb begin
        imm = '0;
        case (itype)
            TYPE_I, TYPE_LOAD: imm = {{20{inst[31]}}, inst[31:20]};
            TYPE_STORE:        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            TYPE_U:            imm = {inst[31:12], 12'b0};
            TYPE_J:            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:           imm = '0;
        endcase
    end

    // Unknown encodings keep every raw field so the RS path sees the full instruction.
    always_comb begin
        rd  = inst[11:7];
        rs1 = inst[19:15];
        rs2 = inst[24:20];
        if (itype == TYPE_STORE || itype == TYPE_B)
            rd = '0;
        if (itype == TYPE_U || itype == TYPE_J)
            rs1 = '0;
        if (itype == TYPE_I || itype == TYPE_LOAD || itype == TYPE_U || itype == TYPE_J)
            rs2 = '0;
    end

    // Bit 30 only distinguishes SUB/SRA/SRAI; elsewhere it is immediate data.
    assign alt  = inst[30] && ((itype == TYPE_R) || (opc == OPC_OPIMM && funct3[1:0] == 2'b01));
    assign code = {alt, ((itype == TYPE_U || itype == TYPE_J) ? 3'b000 : funct3), opc[5:4]};

endmodule

// File: rtl/dispatch_queue.sv
// Instruction buffer between fetch and the RS/LSB: FIFO of fetched instructions with head decode,
// operand resolution against the register file and CDB, and a registered dispatch bundle.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRBW = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             inst_flag,
    input  logic [31:0]      inst,
    input  logic [31:0]      inst_IF_pc,
    input  logic [31:0]      inst_IF_jpc,
    output logic             queue_full,
    input  logic             rob_full,
    input  logic             rs_full,
    input  logic             lsb_full,
    input  logic [ROBBW-1:0] inst_ROB_ava_id,
    output logic [REGBW-1:0] rs1_RF,
    output logic [REGBW-1:0] rs2_RF,
    input  logic [31:0]      V1_RF,
    input  logic [31:0]      V2_RF,
    input  logic [ROBBW-1:0] Q1_RF,
    input  logic [ROBBW-1:0] Q2_RF,
    input  logic             cdb_flag,
    input  logic [ROBBW-1:0] cdb_rob_id,
    input  logic [31:0]      cdb_value,
    output logic             inst_ID_flag,
    output logic [REGBW-1:0] inst_ID_rd,
    output logic [REGBW-1:0] inst_ID_rs1,
    output logic [REGBW-1:0] inst_ID_rs2,
    output logic [31:0]      inst_ID_A,
    output logic [5:0]       inst_ID_code,
    output logic [2:0]       inst_ID_type,
    output logic [31:0]      inst_ID_V1,
    output logic [31:0]      inst_ID_V2,
    output logic [ROBBW-1:0] inst_ID_Q1,
    output logic [ROBBW-1:0] inst_ID_Q2,
    output logic [31:0]      inst_ID_pc,
    output logic [31:0]      inst_ID_jpc,
    output logic [ROBBW-1:0] inst_ID_rob_id,
    output logic             inst_ID_to_lsb
);

    localparam logic [PTRBW:0] FULL_COUNT = (PTRBW+1)'(DEPTH);

    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] jpc_mem  [DEPTH];

    logic [PTRBW-1:0] head;
    logic [PTRBW-1:0] tail;
    logic [PTRBW:0]   count;
    logic [PTRBW:0]   count_next;

    logic [REGBW-1:0] dec_rd;
    logic [REGBW-1:0] dec_rs1;
    logic [REGBW-1:0] dec_rs2;
    logic [31:0]      dec_imm;
    logic [5:0]       dec_code;
    inst_type_e       dec_type;
    logic             dec_to_lsb;

    logic     enq;
    logic     deq;
    operand_t op1;
    operand_t op2;

    dispatch_queue_decoder u_decoder (
        .inst  (inst_mem[head]),
        .rd    (dec_rd),
        .rs1   (dec_rs1),
        .rs2   (dec_rs2),
        .imm   (dec_imm),
        .code  (dec_code),
        .itype (dec_type)
    );

    assign dec_to_lsb = is_lsb_type(dec_type);
    assign rs1_RF     = dec_rs1;
    assign rs2_RF     = dec_rs2;

    assign op1 = resolve_operand(dec_rs1, V1_RF, Q1_RF, cdb_flag, cdb_rob_id, cdb_value);
    assign op2 = resolve_operand(dec_rs2, V2_RF, Q2_RF, cdb_flag, cdb_rob_id, cdb_value);

    // queue_full is registered, so a full queue never accepts even while draining.
    assign enq = inst_flag && !queue_full && !flush;
    assign deq = (count != '0) && !rob_full && !flush && (dec_to_lsb ? !lsb_full : !rs_full);

    always_comb begin
        count_next = count;
        case ({enq, deq})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail] <= inst;
            pc_mem[tail]   <= inst_IF_pc;
            jpc_mem[tail]  <= inst_IF_jpc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            queue_full     <= 1'b0;
            inst_ID_flag   <= 1'b0;
            inst_ID_rd     <= '0;
            inst_ID_rs1    <= '0;
            inst_ID_rs2    <= '0;
            inst_ID_A      <= '0;
            inst_ID_code   <= '0;
            inst_ID_type   <= '0;
            inst_ID_V1     <= '0;
            inst_ID_V2     <= '0;
            inst_ID_Q1     <= '0;
            inst_ID_Q2     <= '0;
            inst_ID_pc     <= '0;
            inst_ID_jpc    <= '0;
            inst_ID_rob_id <= '0;
            inst_ID_to_lsb <= 1'b0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            queue_full   <= 1'b0;
            inst_ID_flag <= 1'b0;
        end else begin
            if (enq)
                tail <= tail + 1'b1;
            if (deq)
                head <= head + 1'b1;
            count        <= count_next;
            queue_full   <= (count_next == FULL_COUNT);
            inst_ID_flag <= deq;
            if (deq) begin
                inst_ID_rd     <= dec_rd;
                inst_ID_rs1    <= dec_rs1;
                inst_ID_rs2    <= dec_rs2;
                inst_ID_A      <= dec_imm;
                inst_ID_code   <= dec_code;
                inst_ID_type   <= dec_type;
                inst_ID_V1     <= op1.v;
                inst_ID_V2     <= op2.v;
                inst_ID_Q1     <= op1.q;
                inst_ID_Q2     <= op2.q;
                inst_ID_pc     <= pc_mem[head];
                inst_ID_jpc    <= jpc_mem[head];
                inst_ID_rob_id <= inst_ROB_ava_id;
                inst_ID_to_lsb <= dec_to_lsb;
            end
        end
    end

endmodule
